// File: rtl/mux_pipe_pkg.sv
// Shared types and helpers for the registered N:1 channel selector.
package mux_pipe_pkg;

  // Width of the select field for a given channel count; never narrower than 1 bit.
  function automatic int sel_width(input int channels);
    return (channels < 2) ? 1 : $clog2(channels);
  endfunction

  // Bit offset of channel `sel` inside the flat channel bus.
  function automatic int unsigned chan_base(input int unsigned sel, input int unsigned width);
    return sel * width;
  endfunction

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/mux_pipe_if.sv
// Beat handshake and data bus between the upstream sources, the selector and the pixel path.
interface mux_pipe_if
  import mux_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int CHANNELS   = 15,
  parameter int SEL_WIDTH  = sel_width(CHANNELS)
) ();

  logic                           i_valid;
  logic                           o_ready;
  logic [SEL_WIDTH-1:0]           i_select;
  logic [CHANNELS*DATA_WIDTH-1:0] i_data;
  logic                           o_valid;
  logic                           i_ready;
  logic [DATA_WIDTH-1:0]          o_q;
  logic [SEL_WIDTH-1:0]           o_sel;

  modport master (
    output i_valid, i_select, i_data, i_ready,
    input  o_ready, o_valid, o_q, o_sel
  );

  modport slave (
    input  i_valid, i_select, i_data, i_ready,
    output o_ready, o_valid, o_q, o_sel
  );

endinterface

// File: rtl/mux_pipe_skid.sv
// Purpose: 2-entry valid/ready register stage (output register plus one skid entry).
// Latency: one cycle from accept to out_vld when the output register is free.
// Backpressure: holds up to two beats; in_rdy is a flop and drops the edge after the skid entry fills.
module mux_pipe_skid #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic             skid_vld;
  logic [WIDTH-1:0] skid_dat;
  logic             in_fire;
  logic             out_free;

  assign in_fire  = in_vld && in_rdy;
  assign out_free = !out_vld || out_rdy;

  // in_rdy always mirrors !skid_vld, so a skid refill and an accept never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_rdy   <= 1'b1;
      out_vld  <= 1'b0;
      out_dat  <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (out_free) begin
      if (skid_vld) begin
        out_vld  <= 1'b1;
        out_dat  <= skid_dat;
        skid_vld <= 1'b0;
        in_rdy   <= 1'b1;
      end else begin
        out_vld <= in_fire;
        if (in_fire) begin
          out_dat <= in_dat;
        end
      end
    end else if (in_fire) begin
      skid_vld <= 1'b1;
      skid_dat <= in_dat;
      in_rdy   <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// Purpose: registered, flow-controlled N:1 channel selector with sticky range error; MUX_PIPE_SCAN_EN adds round-robin scan.
// Latency: one cycle from accept to o_valid/o_q/o_sel.
// Backpressure: two beats held at most, o_ready registered; outputs frozen while o_valid && !i_ready.
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int CHANNELS   = 15,
  parameter int SEL_WIDTH  = sel_width(CHANNELS)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_scan,
  input  logic      i_err_clr,
  output logic      o_range_err,
  mux_pipe_if.slave bus
);

  localparam logic [SEL_WIDTH:0] CH_LIM = (SEL_WIDTH + 1)'(CHANNELS);

  logic                            accept;
  logic [SEL_WIDTH-1:0]            idx;
  logic                            range_bad;
  logic [SEL_WIDTH-1:0]            sel_used;
  logic [DATA_WIDTH-1:0]           word;
  logic [SEL_WIDTH+DATA_WIDTH-1:0] out_dat;

  assign accept = bus.i_valid && bus.o_ready;

`ifdef MUX_PIPE_SCAN_EN
  localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(CHANNELS - 1);

  scan_state_t          scan_st;
  logic [SEL_WIDTH-1:0] scan_cnt;
  logic [SEL_WIDTH-1:0] scan_base;

  // The first scanning cycle after i_scan rises always starts from channel 0.
  assign scan_base = (scan_st == SCAN_IDLE) ? '0 : scan_cnt;
  assign idx       = i_scan ? scan_base : bus.i_select;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_st  <= SCAN_IDLE;
      scan_cnt <= '0;
    end else begin
      scan_st <= i_scan ? SCAN_RUN : SCAN_IDLE;
      if (i_scan && accept) begin
        scan_cnt <= (scan_base == LAST_CH) ? '0 : scan_base + 1'b1;
      end else if (i_scan && (scan_st == SCAN_IDLE)) begin
        scan_cnt <= '0;
      end
    end
  end
`else
  logic unused_scan;
  assign unused_scan = i_scan;
  assign idx         = bus.i_select;
`endif

  assign range_bad = ({1'b0, idx} >= CH_LIM);
  assign sel_used  = range_bad ? '0 : idx;
  assign word      = bus.i_data[chan_base(32'(sel_used), DATA_WIDTH) +: DATA_WIDTH];

  // A new bad beat outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_range_err <= 1'b0;
    end else if (accept && range_bad) begin
      o_range_err <= 1'b1;
    end else if (i_err_clr) begin
      o_range_err <= 1'b0;
    end
  end

  mux_pipe_skid #(
    .WIDTH(SEL_WIDTH + DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (bus.i_valid),
    .in_rdy (bus.o_ready),
    .in_dat ({sel_used, word}),
    .out_vld(bus.o_valid),
    .out_rdy(bus.i_ready),
    .out_dat(out_dat)
  );

  assign bus.o_sel = out_dat[SEL_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign bus.o_q   = out_dat[DATA_WIDTH-1:0];

endmodule
